// File: rtl/xmint_prefetch_buffer.sv
// Instruction fetch front end: issues sequential OBI-style fetches and buffers the
// returned words in a DEPTH-entry FIFO for decode. Redirects flush and drop stale responses.
module xmint_prefetch_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] boot_addr_i,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic        busy_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_GNT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [3:0]    outst_q, outst_d;
  logic [3:0]    discard_q, discard_d;
  logic [3:0]    count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          stale_q, stale_d;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [DEPTH-1:0] err_q;

  logic        gnt_fire, rsp_fire, push, pop;
  logic        issue_ok, issue_next, stale_gnt;
  logic [4:0]  credit_now, credit_next;
  logic [31:0] branch_tgt;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{boot_addr_i[1:0], branch_addr_i[1:0]};
  assign branch_tgt       = {branch_addr_i[31:2], 2'b00};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return {PW{1'b0}};
    else return p + PW'(1);
  endfunction

  always_comb begin
    credit_now  = {1'b0, outst_q} + {1'b0, count_q};
    issue_ok    = req_i & ~branch_i & (credit_now < 5'(DEPTH)) & (discard_q == 4'd0);
    instr_req_o = 1'b0;
    instr_addr_o = fetch_pc_q;
    case (state_q)
      IDLE: begin
        instr_req_o  = issue_ok;
        instr_addr_o = fetch_pc_q;
      end
      WAIT_GNT: begin
        instr_req_o  = 1'b1;
        instr_addr_o = req_addr_q;
      end
      default: begin
        instr_req_o  = 1'b0;
        instr_addr_o = fetch_pc_q;
      end
    endcase

    gnt_fire  = instr_req_o & instr_gnt_i;
    rsp_fire  = instr_rvalid_i & (outst_q != 4'd0);
    valid_o   = (count_q != 4'd0) & ~branch_i;
    pop       = valid_o & ready_i;
    push      = rsp_fire & ~branch_i & (discard_q == 4'd0);
    stale_gnt = gnt_fire & (state_q == WAIT_GNT) & stale_q;
    outst_d   = outst_q + {3'd0, gnt_fire} - {3'd0, rsp_fire};

    // A request still waiting for its grant at a redirect is counted as one extra drop
    if (branch_i) begin
      discard_d = outst_d + {3'd0, (state_q == WAIT_GNT) & ~instr_gnt_i};
    end else if (rsp_fire && (discard_q != 4'd0)) begin
      discard_d = discard_q - 4'd1;
    end else begin
      discard_d = discard_q;
    end

    if (branch_i) begin
      fetch_pc_d = branch_tgt;
      resp_pc_d  = branch_tgt;
      count_d    = 4'd0;
      wr_ptr_d   = {PW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
    end else begin
      fetch_pc_d = (gnt_fire && !stale_gnt) ? fetch_pc_q + 32'd4 : fetch_pc_q;
      resp_pc_d  = push ? resp_pc_q + 32'd4 : resp_pc_q;
      count_d    = count_q + {3'd0, push} - {3'd0, pop};
      wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    end

    credit_next = {1'b0, outst_d} + {1'b0, count_d};
    issue_next  = req_i & ~branch_i & (credit_next < 5'(DEPTH)) & (discard_d == 4'd0);
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    stale_d     = stale_q;
    if (gnt_fire) begin
      if (issue_next) begin
        state_d    = WAIT_GNT;
        req_addr_d = fetch_pc_d;
        stale_d    = 1'b0;
      end else begin
        state_d = IDLE;
        stale_d = 1'b0;
      end
    end else if (state_q == WAIT_GNT) begin
      state_d = WAIT_GNT;
      stale_d = stale_q | branch_i;
    end else if (issue_ok) begin
      state_d    = WAIT_GNT;
      req_addr_d = fetch_pc_q;
      stale_d    = 1'b0;
    end else begin
      state_d = IDLE;
    end
  end

  // Control and pointer state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      fetch_pc_q <= {boot_addr_i[31:2], 2'b00};
      resp_pc_q  <= {boot_addr_i[31:2], 2'b00};
      req_addr_q <= 32'd0;
      outst_q    <= 4'd0;
      discard_q  <= 4'd0;
      count_q    <= 4'd0;
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      stale_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      req_addr_q <= req_addr_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      stale_q    <= stale_d;
    end
  end

  // FIFO payload; entries are only meaningful where count_q covers them
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wr_ptr_q] <= instr_rdata_i;
      pc_q[wr_ptr_q]   <= resp_pc_q;
      err_q[wr_ptr_q]  <= instr_err_i;
    end
  end

  assign rdata_o = data_q[rd_ptr_q];
  assign addr_o  = pc_q[rd_ptr_q];
  assign err_o   = err_q[rd_ptr_q];
  assign busy_o  = (outst_q != 4'd0) | instr_req_o;
endmodule

// File: tb/tb_xmint_prefetch_buffer.sv
// Self-checking bench: bench-side memory and an epoch-tagged scoreboard of what decode must see.
module tb_xmint_prefetch_buffer;
  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni, req_i, branch_i, instr_gnt_i, instr_rvalid_i, instr_err_i, ready_i;
  logic [31:0] boot_addr_i, branch_addr_i, instr_rdata_i;
  logic        instr_req_o, valid_o, err_o, busy_o;
  logic [31:0] instr_addr_o, rdata_o, addr_o;

  always #5 clk_i = ~clk_i;

  xmint_prefetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .boot_addr_i(boot_addr_i), .req_i(req_i),
    .branch_i(branch_i), .branch_addr_i(branch_addr_i), .instr_req_o(instr_req_o),
    .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i), .valid_o(valid_o),
    .ready_i(ready_i), .rdata_o(rdata_o), .addr_o(addr_o), .err_o(err_o), .busy_o(busy_o)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] rsp_addr_q[$];
  int          rsp_ep_q[$];
  logic [31:0] fifo_m[$];
  logic [31:0] gnt_hist[$];
  logic [31:0] pop_addr[$];
  logic        pop_err[$];
  int          cur_epoch = 0;
  logic [31:0] exp_req_pc;
  bit          pend_valid = 0;
  logic [31:0] pend_addr;
  int          pend_epoch;
  bit          force_rv = 0;
  bit          last_req, last_valid;
  int          pops = 0;
  int          cyc_n = 0;
  int          first_rv_cyc, first_valid_cyc;
  int          p0;

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h1234_5678;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return (a == 32'hFFFF_FFFC) || (a[7:2] == 6'h2B);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check outputs, then advance the reference model
  task automatic cyc(input bit rq, input bit br, input logic [31:0] ba, input bit rdy,
                     input bit g, input bit rv);
    bit          rv_eff, stale_any, issue_allowed, rq_o, v;
    int          ep;
    logic [31:0] a, ra;
    @(negedge clk_i);
    req_i = rq; branch_i = br; branch_addr_i = ba; ready_i = rdy; instr_gnt_i = g;
    rv_eff = rv && (rsp_addr_q.size() > 0);
    instr_rvalid_i = rv_eff || force_rv;
    instr_rdata_i  = rv_eff ? mem_of(rsp_addr_q[0]) : 32'hDEAD_BEEF;
    instr_err_i    = rv_eff ? err_of(rsp_addr_q[0]) : 1'b1;
    #1;
    cyc_n++;
    rq_o = instr_req_o;
    v    = valid_o;
    a    = instr_addr_o;
    if (pend_valid) begin
      chk1("req_held", rq_o, 1'b1);
      chk("addr_held", a, pend_addr);
    end
    chk1("valid", v, (fifo_m.size() > 0) && !br);
    chk1("busy", busy_o, (rsp_addr_q.size() > 0) || rq_o);
    stale_any = pend_valid && (pend_epoch != cur_epoch);
    foreach (rsp_ep_q[i]) if (rsp_ep_q[i] != cur_epoch) stale_any = 1'b1;
    issue_allowed = rq && !br && (rsp_addr_q.size() + fifo_m.size() < DEPTH) && !stale_any;
    if (issue_allowed) chk1("req_when_credit", rq_o, 1'b1);
    if (v && rdy && (fifo_m.size() > 0)) begin
      ra = fifo_m.pop_front();
      chk("pop_addr", addr_o, ra);
      chk("pop_data", rdata_o, mem_of(ra));
      chk1("pop_err", err_o, err_of(ra));
      pop_addr.push_back(addr_o);
      pop_err.push_back(err_o);
      pops++;
    end
    if (v && first_valid_cyc < 0) first_valid_cyc = cyc_n;
    if (rv_eff) begin
      if (first_rv_cyc < 0) first_rv_cyc = cyc_n;
      ra = rsp_addr_q.pop_front();
      ep = rsp_ep_q.pop_front();
      if (ep == cur_epoch && !br) fifo_m.push_back(ra);
    end
    if (rq_o && g) begin
      ep = pend_valid ? pend_epoch : cur_epoch;
      if (ep == cur_epoch) begin
        chk("gnt_addr", a, exp_req_pc);
        exp_req_pc += 32'd4;
      end
      rsp_addr_q.push_back(a);
      rsp_ep_q.push_back(ep);
      gnt_hist.push_back(a);
      pend_valid = 1'b0;
    end else if (rq_o && !pend_valid) begin
      pend_valid = 1'b1;
      pend_addr  = a;
      pend_epoch = cur_epoch;
    end
    chk1("credit_limit", (rsp_addr_q.size() + fifo_m.size()) <= DEPTH, 1'b1);
    if (br) begin
      fifo_m.delete();
      cur_epoch++;
      exp_req_pc = {ba[31:2], 2'b00};
    end
    last_req   = rq_o;
    last_valid = v;
  endtask

  task automatic do_reset(input logic [31:0] boot);
    @(negedge clk_i);
    rst_ni = 1'b0; req_i = 1'b0; branch_i = 1'b0; instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b0; ready_i = 1'b0; boot_addr_i = boot; force_rv = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    chk1("rst_req", instr_req_o, 1'b0);
    chk1("rst_valid", valid_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    rsp_addr_q.delete(); rsp_ep_q.delete(); fifo_m.delete();
    pend_valid = 1'b0;
    cur_epoch++;
    exp_req_pc = {boot[31:2], 2'b00};
    rst_ni = 1'b1;
  endtask

  task automatic clear_hist();
    gnt_hist.delete(); pop_addr.delete(); pop_err.delete();
  endtask

  function automatic logic [31:0] qa(input int idx);
    return (pop_addr.size() > idx) ? pop_addr[idx] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] qg(input int idx);
    return (gnt_hist.size() > idx) ? gnt_hist[idx] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic qe(input int idx);
    return (pop_err.size() > idx) ? pop_err[idx] : 1'bx;
  endfunction

  initial begin
    rst_ni = 1'b0; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = 32'd0; boot_addr_i = 32'd0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'd0; instr_err_i = 1'b0;
    ready_i = 1'b0;

    // Boot fetch from an unaligned boot address
    do_reset(32'h0000_0082);
    clear_hist();
    first_rv_cyc = -1; first_valid_cyc = -1;
    repeat (12) cyc(1, 0, 32'd0, 1, 1, 1);
    chk("boot_gnt0", qg(0), 32'h0000_0080);
    chk("boot_gnt1", qg(1), 32'h0000_0084);
    chk("boot_gnt2", qg(2), 32'h0000_0088);
    chk("boot_pop0", qa(0), 32'h0000_0080);
    chk("boot_latency", 32'(first_valid_cyc - first_rv_cyc), 32'd1);

    // Back-pressure: FIFO fills, requests stop, then drain
    do_reset(32'h0000_0000);
    repeat (6) cyc(1, 0, 32'd0, 0, 1, 1);
    chk1("bp_req_stopped", last_req, 1'b0);
    chk1("bp_valid_held", last_valid, 1'b1);
    p0 = pops;
    repeat (8) cyc(1, 0, 32'd0, 1, 1, 1);
    chk1("bp_drain", (pops - p0) >= 4, 1'b1);

    // Redirect with two responses in flight
    do_reset(32'h0000_0100);
    cyc(1, 0, 32'd0, 1, 1, 0);
    cyc(1, 0, 32'd0, 1, 1, 0);
    clear_hist();
    cyc(1, 1, 32'h0000_1000, 1, 0, 1);
    repeat (10) cyc(1, 0, 32'd0, 1, 1, 1);
    chk("br_gnt0", qg(0), 32'h0000_1000);
    chk("br_pop0", qa(0), 32'h0000_1000);

    // Ungranted request at redirect completes at its old address
    do_reset(32'h0000_0040);
    clear_hist();
    cyc(1, 0, 32'd0, 1, 0, 0);
    cyc(1, 1, 32'h0000_2000, 1, 0, 0);
    cyc(1, 0, 32'd0, 1, 0, 0);
    cyc(1, 0, 32'd0, 1, 1, 0);
    repeat (10) cyc(1, 0, 32'd0, 1, 1, 1);
    chk("ungr_gnt0", qg(0), 32'h0000_0040);
    chk("ungr_gnt1", qg(1), 32'h0000_2000);
    chk("ungr_pop0", qa(0), 32'h0000_2000);

    // Error word and PC wrap
    repeat (6) cyc(0, 0, 32'd0, 1, 1, 1);
    clear_hist();
    cyc(1, 1, 32'hFFFF_FFFE, 1, 0, 0);
    repeat (10) cyc(1, 0, 32'd0, 1, 1, 1);
    chk("wrap_gnt0", qg(0), 32'hFFFF_FFFC);
    chk("wrap_gnt1", qg(1), 32'h0000_0000);
    chk("wrap_pop0", qa(0), 32'hFFFF_FFFC);
    chk1("wrap_err0", qe(0), 1'b1);
    chk("wrap_pop1", qa(1), 32'h0000_0000);
    chk1("wrap_err1", qe(1), 1'b0);

    // Reset with requests outstanding; late responses are ignored
    do_reset(32'h0000_0300);
    cyc(1, 0, 32'd0, 0, 1, 0);
    cyc(1, 0, 32'd0, 0, 1, 0);
    do_reset(32'h0000_0500);
    force_rv = 1'b1;
    repeat (3) cyc(0, 0, 32'd0, 1, 0, 0);
    force_rv = 1'b0;
    chk1("rst_late_valid", last_valid, 1'b0);
    chk1("rst_late_req", last_req, 1'b0);
    clear_hist();
    repeat (8) cyc(1, 0, 32'd0, 1, 1, 1);
    chk("rst_restart_gnt", qg(0), 32'h0000_0500);
    chk("rst_restart_pop", qa(0), 32'h0000_0500);

    // Randomized traffic against the scoreboard
    do_reset(32'h0000_0F00);
    p0 = pops;
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0, $urandom,
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
    end
    chk1("rand_progress", (pops - p0) > 100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
